// File: rtl/row_stream_sequencer.sv
// Frame source sequencer: reads pixels row by row from a synchronous frame memory and streams
// them to the 3x3 filter over valid/ready, releasing rows after the preload only on row requests.
module row_stream_sequencer #(
  parameter int IMAGE_WIDTH  = 512,
  parameter int IW_BIT_NUM   = 9,
  parameter int ROW_BITS     = 10,
  parameter int ADDR_WIDTH   = 18,
  parameter int PRELOAD_ROWS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] frame_base,
  input  logic [ROW_BITS-1:0]   frame_rows,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rd_data,
  output logic                  m_data_valid,
  output logic [7:0]            m_data,
  input  logic                  m_data_ready,
  input  logic                  row_req,
  output logic                  req_overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_ROW_END, S_WAIT_REQ, S_DRAIN, S_DONE
  } state_t;

  localparam logic [IW_BIT_NUM-1:0] LAST_COL = IW_BIT_NUM'(IMAGE_WIDTH - 1);
  localparam logic [ROW_BITS-1:0]   PRELOAD  = ROW_BITS'(PRELOAD_ROWS);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [IW_BIT_NUM-1:0] col;
  logic [ROW_BITS-1:0]   rows_issued;
  logic [ROW_BITS-1:0]   rows_total;
  logic [1:0]            pending;
  logic                  in_flight;
  logic [1:0]            fifo_cnt;
  logic [7:0]            head;
  logic [7:0]            tail;

  logic       pop;
  logic       push;
  logic [2:0] occ_sum;
  logic       credit_ok;
  logic       issue;
  logic       rows_remain;
  logic       in_preload;
  logic       req_live;
  logic       pend_dec;

  assign pop          = m_data_valid && m_data_ready;
  assign push         = in_flight;
  // Occupancy plus the read in flight must leave a free slot once this cycle's pop retires.
  assign occ_sum      = {1'b0, fifo_cnt} + {2'b00, in_flight};
  assign credit_ok    = occ_sum < (3'd2 + {2'b00, pop});
  assign issue        = (state == S_ISSUE) && credit_ok;
  assign rows_remain  = rows_issued != rows_total;
  assign in_preload   = rows_issued < PRELOAD;
  assign req_live     = row_req && (state inside {S_ISSUE, S_ROW_END, S_WAIT_REQ});
  // A row_req arriving in WAIT_REQ with nothing pending is consumed by its own grant (net zero).
  assign pend_dec     = ((state == S_ROW_END) && rows_remain && !in_preload && (pending != 2'd0)) ||
                        ((state == S_WAIT_REQ) && ((pending != 2'd0) || row_req));

  assign mem_rd_en    = issue;
  assign mem_addr     = addr;
  assign m_data_valid = fifo_cnt != 2'd0;
  assign m_data       = head;
  assign busy         = (state != S_IDLE) && (state != S_DONE);
  assign done         = state == S_DONE;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      addr         <= '0;
      col          <= '0;
      rows_issued  <= '0;
      rows_total   <= '0;
      pending      <= 2'd0;
      req_overflow <= 1'b0;
    end else begin
      if (req_live && !pend_dec) begin
        if (pending == 2'd3) req_overflow <= 1'b1;
        else                 pending      <= pending + 2'd1;
      end else if (pend_dec && !req_live) begin
        pending <= pending - 2'd1;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            rows_total   <= frame_rows;
            addr         <= frame_base;
            col          <= '0;
            rows_issued  <= '0;
            pending      <= 2'd0;
            req_overflow <= 1'b0;
            state        <= (frame_rows == '0) ? S_DRAIN : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (issue) begin
            addr <= addr + ADDR_WIDTH'(1);
            if (col == LAST_COL) begin
              col         <= '0;
              rows_issued <= rows_issued + ROW_BITS'(1);
              state       <= S_ROW_END;
            end else begin
              col <= col + IW_BIT_NUM'(1);
            end
          end
        end
        S_ROW_END: begin
          if (!rows_remain)                       state <= S_DRAIN;
          else if (in_preload || pending != 2'd0) state <= S_ISSUE;
          else                                    state <= S_WAIT_REQ;
        end
        S_WAIT_REQ: begin
          if (pending != 2'd0 || row_req) state <= S_ISSUE;
        end
        S_DRAIN: begin
          if (fifo_cnt == 2'd0 && !in_flight) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_flight <= 1'b0;
    else          in_flight <= issue;
  end

  // Two-entry output buffer: head drives m_data, tail holds the next pixel.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_cnt <= 2'd0;
      head     <= 8'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) head <= mem_rd_data;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          head     <= tail;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11:   head <= (fifo_cnt == 2'd1) ? mem_rd_data : tail;
        default: ;
      endcase
    end
  end

  // NOTE: tail is storage only (never visible before head loads it), so it carries no reset.
  always_ff @(posedge clk) begin
    if (push && ((!pop && fifo_cnt == 2'd1) || (pop && fifo_cnt == 2'd2))) tail <= mem_rd_data;
  end

endmodule

// File: tb/tb_row_stream_sequencer.sv
// Bench for row_stream_sequencer (IMAGE_WIDTH=4): memory model, pixel/address stream model
// checked every cycle, plus directed frame scenarios.
module tb_row_stream_sequencer;
  localparam int W  = 4;
  localparam int AW = 18;
  localparam int RB = 10;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic [RB-1:0] frame_rows = '0;
  logic          busy, done, mem_rd_en, m_data_valid, req_overflow;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data = 8'd0;
  logic [7:0]    m_data;
  logic          m_data_ready = 1'b0;
  logic          row_req = 1'b0;

  row_stream_sequencer #(
    .IMAGE_WIDTH(W), .IW_BIT_NUM(2), .ROW_BITS(RB), .ADDR_WIDTH(AW), .PRELOAD_ROWS(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .frame_base(frame_base),
    .frame_rows(frame_rows), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .m_data_valid(m_data_valid),
    .m_data(m_data), .m_data_ready(m_data_ready), .row_req(row_req),
    .req_overflow(req_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame memory image: content is a fixed function of the address.
  function automatic logic [7:0] pix(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]};
  endfunction

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pix(mem_addr);

  // Stimulus controls (written by the test sequence only)
  int ready_mode = 1;   // 0 low, 1 high, 2 random
  int auto_req   = 0;
  int burst_req  = 0;
  int frame_id   = 0;
  int start_cyc  = 0;

  // Input driver
  int burst_done = 0;
  int req_sent   = 0;
  int rows_seen_total = 0;
  always @(posedge clk) begin
    #1;
    m_data_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    row_req = 1'b0;
    if (burst_done < burst_req) begin
      row_req = 1'b1;
      burst_done++;
    end else if (auto_req == 0) begin
      req_sent = rows_seen_total;
    end else if (req_sent < rows_seen_total) begin
      row_req = 1'b1;
      req_sent++;
    end
  end

  // Stream model and per-cycle compare
  int mchecks = 0, mfails = 0;
  int mon_frame = 0;
  logic [AW-1:0] m_base;
  int n_xfer, n_reads, done_cnt, done_cyc, first_rd_cyc, first_val_cyc, stalls;
  int xfer_cyc [64];
  logic [AW-1:0] rd_log [64];
  logic [7:0] first_pix, prev_data;
  logic stall_prev = 1'b0;

  task automatic mcheck(input string name, input logic [31:0] act, input logic [31:0] exp);
    mchecks++;
    if (act !== exp) begin
      mfails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_id != mon_frame) begin
      mon_frame = frame_id; m_base = frame_base;
      n_xfer = 0; n_reads = 0; done_cnt = 0; done_cyc = -1;
      first_rd_cyc = -1; first_val_cyc = -1; stalls = 0;
    end
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (mem_rd_en) begin
        mcheck("rd_addr", 32'(mem_addr), 32'(AW'(m_base + AW'(n_reads))));
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        rd_log[n_reads % 64] = mem_addr;
        n_reads++;
      end
      if (stall_prev) begin
        stalls++;
        mcheck("hold_valid", 32'(m_data_valid), 32'd1);
        mcheck("hold_data", 32'(m_data), 32'(prev_data));
      end
      if (m_data_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (m_data_valid && m_data_ready) begin
        mcheck("pixel", 32'(m_data), 32'(pix(AW'(m_base + AW'(n_xfer)))));
        if (n_xfer == 0) first_pix = m_data;
        xfer_cyc[n_xfer % 64] = cyc;
        n_xfer++;
        if (n_xfer % W == 0) rows_seen_total++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = m_data_valid && !m_data_ready;
      prev_data  = m_data;
    end
  end

  // Sequence-level checks
  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [AW-1:0] base, input logic [RB-1:0] rows);
    @(posedge clk); #1;
    frame_base = base; frame_rows = rows; start = 1'b1;
    frame_id++; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    int k = 0;
    while (done_cnt == 0 && k < max) begin
      tick(1);
      k++;
    end
    tick(3);
    check(name, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    tick(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_valid", 32'(m_data_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_ovf", 32'(req_overflow), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // 5 rows, ready high, one request per delivered row
    ready_mode = 1; auto_req = 1;
    start_frame(18'h00123, 5);
    wait_done(150, "t1_done");
    check("t1_xfers", 32'(n_xfer), 32'd20);
    check("t1_reads", 32'(n_reads), 32'd20);
    check("t1_first_pix", 32'(first_pix), 32'h22);
    check("t1_rd_latency", 32'(first_rd_cyc - start_cyc), 32'd1);
    check("t1_valid_latency", 32'(first_val_cyc - start_cyc), 32'd3);
    for (int r = 0; r < 5; r++)
      check("t1_row_rate", 32'(xfer_cyc[4*r+3] - xfer_cyc[4*r]), 32'd3);
    check("t1_ovf", 32'(req_overflow), 32'd0);

    // 5 rows, no request: preload only, then stall
    auto_req = 0;
    start_frame(18'h00200, 5);
    tick(60);
    check("t2_xfers", 32'(n_xfer), 32'd12);
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_no_done", 32'(done_cnt), 32'd0);
    check("t2_no_rd", 32'(mem_rd_en), 32'd0);
    frame_base = 18'h03000; frame_rows = 1; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(5);
    check("t2_start_ignored", 32'(n_xfer), 32'd12);
    burst_req += 2;
    wait_done(150, "t2_done");
    check("t2_xfers_final", 32'(n_xfer), 32'd20);

    // random backpressure
    ready_mode = 2; auto_req = 1;
    start_frame(18'h001F0, 4);
    wait_done(600, "t3_done");
    check("t3_xfers", 32'(n_xfer), 32'd16);
    check("t3_saw_stall", 32'(stalls > 0), 32'd1);

    // four back-to-back requests during preload
    ready_mode = 1; auto_req = 0;
    start_frame(18'h00400, 6);
    burst_req += 4;
    tick(6);
    check("t4_ovf_set", 32'(req_overflow), 32'd1);
    wait_done(200, "t4_done");
    check("t4_xfers", 32'(n_xfer), 32'd24);
    check("t4_ovf_sticky", 32'(req_overflow), 32'd1);

    // empty frame
    start_frame(18'h00000, 0);
    check("t5_ovf_cleared", 32'(req_overflow), 32'd0);
    wait_done(10, "t5_done");
    check("t5_done_cycle", 32'(done_cyc - start_cyc), 32'd2);
    check("t5_reads", 32'(n_reads), 32'd0);

    // two rows, below preload
    start_frame(18'h00800, 2);
    wait_done(100, "t6_done");
    check("t6_xfers", 32'(n_xfer), 32'd8);

    // reset mid-row, then restart across the address wrap
    auto_req = 1;
    start_frame(18'h00040, 5);
    tick(6);
    reset_n = 1'b0;
    #1;
    check("t7_rst_busy", 32'(busy), 32'd0);
    check("t7_rst_valid", 32'(m_data_valid), 32'd0);
    check("t7_rst_rd_en", 32'(mem_rd_en), 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);
    check("t7_no_done", 32'(done_cnt), 32'd0);
    start_frame(18'h3FFFE, 2);
    wait_done(100, "t7_done");
    check("t7_xfers", 32'(n_xfer), 32'd8);
    check("t7_wrap_addr", 32'(rd_log[2]), 32'h00000);
    check("t7_first_pix", 32'(first_pix), 32'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks + mchecks, failures + mfails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
